// File: rtl/epass_pkg.sv
// Shared constants, FSM encoding, table write payload and saturating helper for the E-pass validator.
package epass_pkg;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned BAL_W  = 16;
    localparam int unsigned UNIT_W = 8;

    localparam logic [1:0] EP_PENDING = 2'b00;
    localparam logic [1:0] EP_ACCEPT  = 2'b10;
    localparam logic [1:0] EP_REJECT  = 2'b01;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_TIMING    = 3'd1;
    localparam state_t ST_WAIT_CARD = 3'd2;
    localparam state_t ST_LOOKUP    = 3'd3;
    localparam state_t ST_DECIDE    = 3'd4;
    localparam state_t ST_RESULT    = 3'd5;

    // Merged table write: deduction result and host top-up may land in the same cycle.
    typedef struct packed {
        logic             ded_en;
        logic [ID_W-1:0]  ded_id;
        logic [BAL_W-1:0] ded_bal;
        logic             tu_en;
        logic [ID_W-1:0]  tu_id;
        logic [BAL_W-1:0] tu_amt;
    } tbl_wr_t;

    localparam int unsigned TBL_WR_W = $bits(tbl_wr_t);

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/balance_table.sv
// Per-card balance registers: one async read port and one merged deduct/top-up write port.
module balance_table
    import epass_pkg::*;
#(
    parameter int unsigned NUM_CARDS = 8,
    parameter int unsigned INIT_BAL  = 100
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ID_W-1:0]     rd_id,
    output logic [BAL_W-1:0]    rd_bal,
    input  logic [TBL_WR_W-1:0] wr
);

    localparam logic [BAL_W-1:0] BAL_MAX = '1;

    tbl_wr_t          wr_s;
    logic [BAL_W-1:0] mem     [NUM_CARDS];
    logic [BAL_W-1:0] mem_nxt [NUM_CARDS];

    assign wr_s = tbl_wr_t'(wr);

    always_comb begin
        rd_bal = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (rd_id == ID_W'(i)) rd_bal = mem[i];
        end
    end

    // Top-up is applied on top of the deducted value when both hit the same entry.
    always_comb begin
        for (int i = 0; i < NUM_CARDS; i++) begin
            mem_nxt[i] = mem[i];
            if (wr_s.ded_en && wr_s.ded_id == ID_W'(i)) mem_nxt[i] = wr_s.ded_bal;
            if (wr_s.tu_en && wr_s.tu_id == ID_W'(i))
                mem_nxt[i] = BAL_W'(sat_add(32'(mem_nxt[i]), 32'(wr_s.tu_amt), 32'(BAL_MAX)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CARDS; i++) mem[i] <= BAL_W'(INIT_BAL);
        end else begin
            for (int i = 0; i < NUM_CARDS; i++) mem[i] <= mem_nxt[i];
        end
    end

endmodule

// File: rtl/epass_validator.sv
// Times a vehicle, accepts one RFID card, charges the fee against the balance table and
// answers the toll controller's cal request with a 2-bit verdict.
module epass_validator
    import epass_pkg::*;
#(
    parameter int unsigned NUM_CARDS = 8,
    parameter int unsigned INIT_BAL  = 100,
    parameter int unsigned BASE_FEE  = 10,
    parameter int unsigned RATE      = 2,
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             count,
    input  logic             cal,
    input  logic [ID_W-1:0]  card_id,
    input  logic             card_valid,
    output logic             card_ready,
    input  logic             topup_valid,
    input  logic [ID_W-1:0]  topup_id,
    input  logic [BAL_W-1:0] topup_amt,
    output logic [1:0]       valid_Epass,
    output logic [BAL_W-1:0] fee,
    output logic [BAL_W-1:0] balance_out,
    output logic             busy
);

    localparam int unsigned      PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned      TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [BAL_W-1:0] BAL_MAX = '1;

    state_t              state, state_d;
    logic [PRE_W-1:0]    presc, presc_d;
    logic [UNIT_W-1:0]   units, units_d;
    logic [TMO_W-1:0]    tmo, tmo_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [BAL_W-1:0]    bal_q, bal_d;
    logic [BAL_W-1:0]    fee_q, fee_d;
    logic [BAL_W-1:0]    fee_out_d, bal_out_d, rd_bal;
    logic [1:0]          verdict_d;
    logic                ready_d, busy_d, xfer_c;
    logic [BAL_W-1:0]    fee_calc_c;
    tbl_wr_t             wr;

    assign xfer_c     = card_valid && card_ready;
    assign fee_calc_c = BAL_W'(sat_add(32'(BASE_FEE), 32'(RATE) * 32'(units), 32'(BAL_MAX)));

    always_comb begin
        state_d   = state;
        presc_d   = presc;
        units_d   = units;
        tmo_d     = tmo;
        id_d      = id_q;
        bal_d     = bal_q;
        fee_d     = fee_q;
        fee_out_d = fee;
        bal_out_d = balance_out;
        verdict_d = valid_Epass;
        wr        = '0;

        case (state)
            ST_IDLE: begin
                if (cal) begin
                    state_d = ST_WAIT_CARD;
                    units_d = '0;
                    tmo_d   = '0;
                end else if (count) begin
                    state_d = ST_TIMING;
                    presc_d = '0;
                    units_d = '0;
                end
            end
            ST_TIMING: begin
                if (count) begin
                    if (presc == PRE_W'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        if (units != '1) units_d = units + UNIT_W'(1);
                    end else begin
                        presc_d = presc + PRE_W'(1);
                    end
                end
                if (cal) begin
                    state_d = ST_WAIT_CARD;
                    tmo_d   = '0;
                end
            end
            ST_WAIT_CARD: begin
                if (!cal) begin
                    state_d = ST_IDLE;
                end else if (xfer_c) begin
                    id_d    = card_id;
                    state_d = ST_LOOKUP;
                end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                    verdict_d = EP_REJECT;
                    fee_out_d = '0;
                    bal_out_d = '0;
                    state_d   = ST_RESULT;
                end else begin
                    tmo_d = tmo + TMO_W'(1);
                end
            end
            ST_LOOKUP: begin
                if (!cal) begin
                    state_d = ST_IDLE;
                end else if (32'(id_q) >= NUM_CARDS) begin
                    verdict_d = EP_REJECT;
                    fee_out_d = fee_calc_c;
                    bal_out_d = '0;
                    state_d   = ST_RESULT;
                end else begin
                    bal_d   = rd_bal;
                    fee_d   = fee_calc_c;
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (!cal) begin
                    state_d = ST_IDLE;
                end else begin
                    fee_out_d = fee_q;
                    state_d   = ST_RESULT;
                    if (bal_q >= fee_q) begin
                        wr.ded_en  = 1'b1;
                        wr.ded_id  = id_q;
                        wr.ded_bal = bal_q - fee_q;
                        verdict_d  = EP_ACCEPT;
                        bal_out_d  = bal_q - fee_q;
                    end else begin
                        verdict_d  = EP_REJECT;
                        bal_out_d  = bal_q;
                    end
                end
            end
            ST_RESULT: begin
                if (!cal) begin
                    state_d   = ST_IDLE;
                    verdict_d = EP_PENDING;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr.tu_en  = topup_valid;
        wr.tu_id  = topup_id;
        wr.tu_amt = topup_amt;
        ready_d   = (state_d == ST_WAIT_CARD);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            presc       <= '0;
            units       <= '0;
            tmo         <= '0;
            id_q        <= '0;
            bal_q       <= '0;
            fee_q       <= '0;
            card_ready  <= 1'b0;
            valid_Epass <= EP_PENDING;
            fee         <= '0;
            balance_out <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            presc       <= presc_d;
            units       <= units_d;
            tmo         <= tmo_d;
            id_q        <= id_d;
            bal_q       <= bal_d;
            fee_q       <= fee_d;
            card_ready  <= ready_d;
            valid_Epass <= verdict_d;
            fee         <= fee_out_d;
            balance_out <= bal_out_d;
            busy        <= busy_d;
        end
    end

    balance_table #(
        .NUM_CARDS (NUM_CARDS),
        .INIT_BAL  (INIT_BAL)
    ) u_table (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_id   (id_q),
        .rd_bal  (rd_bal),
        .wr      (wr)
    );

endmodule
